pc_unit: RTL and testbench

Parametrised program-counter unit for the multicycle MIPS datapath. It holds the PC register and selects the next PC from the ALU result, ALUOut or a jump target formed internally. It evaluates four conditional-branch modes and handles exception redirect and return, with EPC, Cause and an exception-level flag. It sits between the control FSM, the ALU and the instruction memory address port.

---
 rtl/pc_pkg.sv | 36 +++
 rtl/pc_next_sel.sv | 49 ++++
 rtl/pc_unit.sv | 107 ++++++++++
 tb/tb_pc_unit.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared types and constants for the multicycle MIPS program-counter unit.
// Enum values match the encodings driven by the control FSM.
package pc_pkg;

    typedef enum logic [1:0] {
        ALU_PLUS4 = 2'b00,
        ALU_OUT   = 2'b01,
        JUMP      = 2'b10,
        HOLD      = 2'b11
    } pc_src_e;

    typedef enum logic [1:0] {
        BEQ  = 2'b00,
        BNE  = 2'b01,
        BLEZ = 2'b10,
        BGTZ = 2'b11
    } br_mode_e;

    localparam int unsigned CAUSE_ADEL = 4;
    localparam int unsigned CAUSE_RI   = 10;
    localparam int unsigned CAUSE_OV   = 12;

    function automatic logic branch_taken(input br_mode_e mode, input logic zero,
                                          input logic neg);
        logic taken;
        unique case (mode)
            BEQ:     taken = zero;
            BNE:     taken = !zero;
            BLEZ:    taken = zero | neg;
            BGTZ:    taken = !zero & !neg;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC selection: target mux, jump-target formation,
// branch evaluation, write enable and misalignment detection.
module pc_next_sel
    import pc_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] alu_result,
    input  logic [WIDTH-1:0] alu_out,
    input  logic [25:0]      jump_index,
    input  logic [1:0]       pc_source,
    input  logic [1:0]       branch_mode,
    input  logic             zero,
    input  logic             neg,
    input  logic             pc_write,
    input  logic             pc_write_cond,
    output logic [WIDTH-1:0] target,
    output logic             we,
    output logic             misaligned
);

    pc_src_e          src;
    br_mode_e         mode;
    logic             taken;
    logic [WIDTH-1:0] jump_target;

    assign src  = pc_src_e'(pc_source);
    assign mode = br_mode_e'(branch_mode);

    // PC already holds PC+4 here; keep its region bits above the 28-bit jump field.
    assign jump_target = {pc[WIDTH-1:28], jump_index, 2'b00};

    always_comb begin
        target = pc;
        unique case (src)
            ALU_PLUS4: target = alu_result;
            ALU_OUT:   target = alu_out;
            JUMP:      target = jump_target;
            HOLD:      target = pc;
            default:   target = pc;
        endcase
    end

    assign taken      = branch_taken(mode, zero, neg);
    assign we         = pc_write | (pc_write_cond & taken);
    assign misaligned = we & (target[1:0] != 2'b00);

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: PC, EPC, Cause and EXL registers with exception
// redirect/return priority; next-PC selection lives in pc_next_sel.
module pc_unit
    import pc_pkg::*;
#(
    parameter int unsigned     WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [WIDTH-1:0] EXC_VECTOR   = 32'h0000_0180,
    parameter int unsigned     CAUSE_W      = 5
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic [WIDTH-1:0]   ALUresult,
    input  logic [WIDTH-1:0]   ALUout,
    input  logic [25:0]        JumpIndex,
    input  logic [1:0]         PCsource,
    input  logic               PCwrite,
    input  logic               PCwriteCond,
    input  logic [1:0]         BranchMode,
    input  logic               Zero,
    input  logic               Neg,
    input  logic               ExcReq,
    input  logic [CAUSE_W-1:0] ExcCode,
    input  logic               Eret,
    output logic [WIDTH-1:0]   PC,
    output logic [WIDTH-1:0]   EPC,
    output logic [CAUSE_W-1:0] Cause,
    output logic               EXL,
    output logic               Redirect
);

    logic [WIDTH-1:0]   pc_q, pc_d;
    logic [WIDTH-1:0]   epc_q, epc_d;
    logic [CAUSE_W-1:0] cause_q, cause_d;
    logic               exl_q, exl_d;
    logic               redirect_q, redirect_d;

    logic [WIDTH-1:0]   target;
    logic               we;
    logic               misaligned;

    pc_next_sel #(
        .WIDTH(WIDTH)
    ) u_next_sel (
        .pc            (pc_q),
        .alu_result    (ALUresult),
        .alu_out       (ALUout),
        .jump_index    (JumpIndex),
        .pc_source     (PCsource),
        .branch_mode   (BranchMode),
        .zero          (Zero),
        .neg           (Neg),
        .pc_write      (PCwrite),
        .pc_write_cond (PCwriteCond),
        .target        (target),
        .we            (we),
        .misaligned    (misaligned)
    );

    always_comb begin
        pc_d       = pc_q;
        epc_d      = epc_q;
        cause_d    = cause_q;
        exl_d      = exl_q;
        redirect_d = 1'b0;

        if (ExcReq || misaligned) begin
            // A nested exception keeps the EPC of the outermost one.
            if (!exl_q) begin
                epc_d = pc_q;
            end
            cause_d    = ExcReq ? ExcCode : CAUSE_W'(CAUSE_ADEL);
            exl_d      = 1'b1;
            pc_d       = EXC_VECTOR;
            redirect_d = 1'b1;
        end else if (Eret && exl_q) begin
            pc_d       = epc_q;
            exl_d      = 1'b0;
            redirect_d = 1'b1;
        end else if (we) begin
            pc_d = target;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            pc_q       <= RESET_VECTOR;
            epc_q      <= '0;
            cause_q    <= '0;
            exl_q      <= 1'b0;
            redirect_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            epc_q      <= epc_d;
            cause_q    <= cause_d;
            exl_q      <= exl_d;
            redirect_q <= redirect_d;
        end
    end

    assign PC       = pc_q;
    assign EPC      = epc_q;
    assign Cause    = cause_q;
    assign EXL      = exl_q;
    assign Redirect = redirect_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit with hand-computed expectations.
module tb_pc_unit;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [31:0] ALUresult;
    logic [31:0] ALUout;
    logic [25:0] JumpIndex;
    logic [1:0]  PCsource;
    logic        PCwrite;
    logic        PCwriteCond;
    logic [1:0]  BranchMode;
    logic        Zero;
    logic        Neg;
    logic        ExcReq;
    logic [4:0]  ExcCode;
    logic        Eret;
    logic [31:0] PC;
    logic [31:0] EPC;
    logic [4:0]  Cause;
    logic        EXL;
    logic        Redirect;

    int n_checks = 0;
    int n_fail   = 0;

    pc_unit dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .ALUresult   (ALUresult),
        .ALUout      (ALUout),
        .JumpIndex   (JumpIndex),
        .PCsource    (PCsource),
        .PCwrite     (PCwrite),
        .PCwriteCond (PCwriteCond),
        .BranchMode  (BranchMode),
        .Zero        (Zero),
        .Neg         (Neg),
        .ExcReq      (ExcReq),
        .ExcCode     (ExcCode),
        .Eret        (Eret),
        .PC          (PC),
        .EPC         (EPC),
        .Cause       (Cause),
        .EXL         (EXL),
        .Redirect    (Redirect)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic idle();
        Reset       = 1'b0;
        ALUresult   = '0;
        ALUout      = '0;
        JumpIndex   = '0;
        PCsource    = 2'b00;
        PCwrite     = 1'b0;
        PCwriteCond = 1'b0;
        BranchMode  = 2'b00;
        Zero        = 1'b0;
        Neg         = 1'b0;
        ExcReq      = 1'b0;
        ExcCode     = '0;
        Eret        = 1'b0;
    endtask

    // One clock edge; outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic load_pc(input logic [31:0] v);
        idle();
        PCwrite   = 1'b1;
        PCsource  = 2'b00;
        ALUresult = v;
        step();
        idle();
    endtask

    task automatic branch(input logic [1:0] mode, input logic z, input logic n,
                          input logic [31:0] exp, input string tag);
        load_pc(32'h40);
        PCwriteCond = 1'b1;
        PCsource    = 2'b01;
        ALUout      = 32'h100;
        BranchMode  = mode;
        Zero        = z;
        Neg         = n;
        step();
        check(tag, PC, exp);
        idle();
    endtask

    initial begin
        idle();
        Reset = 1'b1;
        step();
        step();
        check("rst_pc", PC, 32'h0);
        check("rst_epc", EPC, 32'h0);
        check("rst_cause", 32'(Cause), 32'h0);
        check("rst_exl", 32'(EXL), 32'h0);
        check("rst_redirect", 32'(Redirect), 32'h0);

        idle();
        PCwrite   = 1'b1;
        ALUresult = 32'h4;
        step();
        check("seq_pc4", PC, 32'h4);
        check("seq_redirect", 32'(Redirect), 32'h0);

        branch(2'b00, 1'b1, 1'b0, 32'h100, "beq_taken");
        branch(2'b01, 1'b1, 1'b0, 32'h40, "bne_not_taken");
        branch(2'b11, 1'b0, 1'b0, 32'h100, "bgtz_taken");
        branch(2'b10, 1'b0, 1'b0, 32'h40, "blez_not_taken");
        branch(2'b10, 1'b0, 1'b1, 32'h100, "blez_neg_taken");
        branch(2'b11, 1'b0, 1'b1, 32'h40, "bgtz_neg_not_taken");

        load_pc(32'h9000_0010);
        PCwrite   = 1'b1;
        PCsource  = 2'b10;
        JumpIndex = 26'h0000123;
        step();
        check("jump_pc", PC, 32'h9000_048C);
        idle();

        load_pc(32'h200);
        ExcReq  = 1'b1;
        ExcCode = 5'd12;
        step();
        check("exc_pc", PC, 32'h180);
        check("exc_epc", EPC, 32'h200);
        check("exc_cause", 32'(Cause), 32'd12);
        check("exc_exl", 32'(EXL), 32'h1);
        check("exc_redirect", 32'(Redirect), 32'h1);
        idle();
        step();
        check("exc_redirect_drop", 32'(Redirect), 32'h0);
        check("exc_pc_hold", PC, 32'h180);

        ExcReq  = 1'b1;
        ExcCode = 5'd10;
        step();
        check("nest_cause", 32'(Cause), 32'd10);
        check("nest_epc", EPC, 32'h200);
        check("nest_redirect", 32'(Redirect), 32'h1);
        idle();

        Eret = 1'b1;
        step();
        check("eret_pc", PC, 32'h200);
        check("eret_exl", 32'(EXL), 32'h0);
        check("eret_repulse", 32'(Redirect), 32'h1);
        idle();
        step();
        check("eret_redirect_drop", 32'(Redirect), 32'h0);

        Eret = 1'b1;
        step();
        check("eret_noexl_pc", PC, 32'h200);
        check("eret_noexl_redirect", 32'(Redirect), 32'h0);
        idle();

        ExcReq  = 1'b1;
        ExcCode = 5'd12;
        step();
        idle();
        Eret    = 1'b1;
        ExcReq  = 1'b1;
        ExcCode = 5'd10;
        step();
        check("eret_exc_pc", PC, 32'h180);
        check("eret_exc_exl", 32'(EXL), 32'h1);
        check("eret_exc_cause", 32'(Cause), 32'd10);
        check("eret_exc_epc", EPC, 32'h200);
        idle();

        Eret      = 1'b1;
        PCwrite   = 1'b1;
        ALUresult = 32'h300;
        step();
        check("eret_over_we_pc", PC, 32'h200);
        check("eret_over_we_exl", 32'(EXL), 32'h0);
        idle();

        PCwrite  = 1'b1;
        PCsource = 2'b01;
        ALUout   = 32'h102;
        step();
        check("mis_pc", PC, 32'h180);
        check("mis_cause", 32'(Cause), 32'd4);
        check("mis_epc", EPC, 32'h200);
        check("mis_exl", 32'(EXL), 32'h1);
        idle();

        PCwrite  = 1'b1;
        PCsource = 2'b11;
        step();
        check("hold_pc", PC, 32'h180);
        check("hold_cause", 32'(Cause), 32'd4);
        idle();

        Reset   = 1'b1;
        ExcReq  = 1'b1;
        ExcCode = 5'd12;
        step();
        check("rst_exc_pc", PC, 32'h0);
        check("rst_exc_epc", EPC, 32'h0);
        check("rst_exc_cause", 32'(Cause), 32'h0);
        check("rst_exc_exl", 32'(EXL), 32'h0);
        check("rst_exc_redirect", 32'(Redirect), 32'h0);
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
